// File: rtl/src_bus_datapath_pkg.sv
// +----------------------------------------------------------------------+
// | Package   : src_dp_pkg                                               |
// | Purpose   : Shared types and constants for the Mini SRC datapath:    |
// |             ALU op encodings, memory FSM states, bus source order.   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package src_dp_pkg;

  // ALU operation encodings driven by the control unit
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SHL = 3'd4,
    ALU_SHR = 3'd5,
    ALU_NEG = 3'd6,
    ALU_NOT = 3'd7
  } alu_op_e;

  // Memory handshake FSM states
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Bus sources; the enum value is the bit position in the source-select vector
  typedef enum logic [3:0] {
    SRC_PC     = 4'd0,
    SRC_MDR    = 4'd1,
    SRC_ZHI    = 4'd2,
    SRC_ZLO    = 4'd3,
    SRC_HI     = 4'd4,
    SRC_LO     = 4'd5,
    SRC_INPORT = 4'd6,
    SRC_GPR    = 4'd7,
    SRC_BA     = 4'd8
  } bus_src_e;

  localparam int c_NUM_BUS_SRC = 9;

  // Bus priority, highest first
  localparam bus_src_e c_BUS_PRIO [c_NUM_BUS_SRC] = '{
    SRC_PC, SRC_MDR, SRC_ZHI, SRC_ZLO, SRC_HI, SRC_LO, SRC_INPORT, SRC_GPR, SRC_BA
  };

  // Number of out-strobes asserted at once
  function automatic logic [3:0] count_bus_src(input logic [c_NUM_BUS_SRC-1:0] sel);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < c_NUM_BUS_SRC; i++) begin
      cnt = cnt + {3'b000, sel[i]};
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/src_bus_datapath_if.sv
// +----------------------------------------------------------------------+
// | Interface : src_bus_datapath_if                                      |
// | Purpose   : Control strobes, bus observation and memory handshake    |
// |             signals of the datapath. slave = datapath view,          |
// |             master = control unit / memory view.                     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

interface src_bus_datapath_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 9
);
  localparam int c_SEL_W = $clog2(NUM_REGS);

  logic [c_SEL_W-1:0] reg_sel_i;
  logic               reg_in_i, reg_out_i, ba_out_i;
  logic               pc_in_i, pc_out_i, inc_pc_i;
  logic               mar_in_i, mdr_in_i, mdr_out_i;
  logic               y_in_i, z_in_i, zhi_out_i, zlo_out_i;
  logic               hi_in_i, hi_out_i, lo_in_i, lo_out_i;
  logic               inport_out_i, outport_in_i;
  logic [2:0]         alu_op_i;
  logic               mem_rd_i, mem_wr_i;
  logic [DATA_W-1:0]  in_data_i;
  logic [DATA_W-1:0]  bus_out_o;
  logic [DATA_W-1:0]  out_data_o;
  logic               mem_busy_o, mem_done_o;
  logic               mem_req_o, mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic               mem_ack_i;
  logic [DATA_W-1:0]  mem_rdata_i;
  logic               bus_err_o;

  modport slave (
    input  reg_sel_i, reg_in_i, reg_out_i, ba_out_i,
    input  pc_in_i, pc_out_i, inc_pc_i, mar_in_i, mdr_in_i, mdr_out_i,
    input  y_in_i, z_in_i, zhi_out_i, zlo_out_i, hi_in_i, hi_out_i, lo_in_i, lo_out_i,
    input  inport_out_i, outport_in_i, alu_op_i, mem_rd_i, mem_wr_i, in_data_i,
    input  mem_ack_i, mem_rdata_i,
    output bus_out_o, out_data_o, mem_busy_o, mem_done_o, mem_req_o, mem_we_o,
    output mem_addr_o, mem_wdata_o, bus_err_o
  );

  modport master (
    output reg_sel_i, reg_in_i, reg_out_i, ba_out_i,
    output pc_in_i, pc_out_i, inc_pc_i, mar_in_i, mdr_in_i, mdr_out_i,
    output y_in_i, z_in_i, zhi_out_i, zlo_out_i, hi_in_i, hi_out_i, lo_in_i, lo_out_i,
    output inport_out_i, outport_in_i, alu_op_i, mem_rd_i, mem_wr_i, in_data_i,
    output mem_ack_i, mem_rdata_i,
    input  bus_out_o, out_data_o, mem_busy_o, mem_done_o, mem_req_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o, bus_err_o
  );

endinterface

`default_nettype wire

// File: rtl/src_bus_datapath_alu.sv
// +----------------------------------------------------------------------+
// | Module    : src_dp_alu                                               |
// | Purpose   : Combinational ALU. A = Y register, B = bus. Produces the |
// |             ZLO result and ZHI (carry/borrow for ADD/SUB, else 0).   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module src_dp_alu
  import src_dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);

  localparam int c_SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [c_SH_W-1:0] w_sh;

  // Extra top bit holds carry out (ADD) or borrow (SUB, set when A < B)
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} - {1'b0, b_i};
  assign w_sh   = b_i[c_SH_W-1:0];

  // Operation select; ZHI stays zero except for the carry/borrow ops
  always_comb begin
    lo_o = '0;
    hi_o = '0;
    unique case (op_i)
      ALU_ADD: begin
        lo_o = w_sum[DATA_W-1:0];
        hi_o = {{(DATA_W-1){1'b0}}, w_sum[DATA_W]};
      end
      ALU_SUB: begin
        lo_o = w_diff[DATA_W-1:0];
        hi_o = {{(DATA_W-1){1'b0}}, w_diff[DATA_W]};
      end
      ALU_AND: lo_o = a_i & b_i;
      ALU_OR:  lo_o = a_i | b_i;
      ALU_SHL: lo_o = a_i << w_sh;
      ALU_SHR: lo_o = a_i >> w_sh;
      ALU_NEG: lo_o = '0 - b_i;
      ALU_NOT: lo_o = ~b_i;
      default: lo_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/src_bus_datapath.sv
// +----------------------------------------------------------------------+
// | Module    : src_bus_datapath                                         |
// | Purpose   : Parametrised single-bus Mini SRC datapath: register file,|
// |             PC, MAR/MDR, Y/Z/HI/LO, I/O ports, bus mux, ALU and a    |
// |             req/ack memory handshake FSM tolerating wait states.     |
// | Options   : SRC_DP_BUS_CHECK_EN - build the sticky bus-contention    |
// |             flag; otherwise bus_err_o is tied low.                   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module src_bus_datapath
  import src_dp_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter int                ADDR_W   = 9,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  src_bus_datapath_if.slave dp
);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] pc_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic [DATA_W-1:0] inport_q, outport_q;
  logic [ADDR_W-1:0] mar_q;
  mem_state_e        state_q, state_d;
  logic              we_q, we_d;

  logic [DATA_W-1:0]        w_bus;
  logic [DATA_W-1:0]        w_alu_lo, w_alu_hi;
  logic [DATA_W-1:0]        w_gpr_rd;
  logic [c_NUM_BUS_SRC-1:0] w_src_sel;
  logic [DATA_W-1:0]        w_src_val [c_NUM_BUS_SRC];
  logic                     w_rd_load;

  assign w_gpr_rd = gpr_q[dp.reg_sel_i];

  assign w_src_sel[SRC_PC]     = dp.pc_out_i;
  assign w_src_sel[SRC_MDR]    = dp.mdr_out_i;
  assign w_src_sel[SRC_ZHI]    = dp.zhi_out_i;
  assign w_src_sel[SRC_ZLO]    = dp.zlo_out_i;
  assign w_src_sel[SRC_HI]     = dp.hi_out_i;
  assign w_src_sel[SRC_LO]     = dp.lo_out_i;
  assign w_src_sel[SRC_INPORT] = dp.inport_out_i;
  assign w_src_sel[SRC_GPR]    = dp.reg_out_i;
  assign w_src_sel[SRC_BA]     = dp.ba_out_i;

  assign w_src_val[SRC_PC]     = pc_q;
  assign w_src_val[SRC_MDR]    = mdr_q;
  assign w_src_val[SRC_ZHI]    = zhi_q;
  assign w_src_val[SRC_ZLO]    = zlo_q;
  assign w_src_val[SRC_HI]     = hi_q;
  assign w_src_val[SRC_LO]     = lo_q;
  assign w_src_val[SRC_INPORT] = inport_q;
  assign w_src_val[SRC_GPR]    = w_gpr_rd;
  // R0 reads as zero only when used as a base address
  assign w_src_val[SRC_BA]     = (dp.reg_sel_i == '0) ? '0 : w_gpr_rd;

  // Bus mux: walk from lowest to highest priority so the highest asserted source wins
  always_comb begin
    w_bus = '0;
    for (int i = c_NUM_BUS_SRC - 1; i >= 0; i--) begin
      if (w_src_sel[c_BUS_PRIO[i]]) begin
        w_bus = w_src_val[c_BUS_PRIO[i]];
      end
    end
  end

  src_dp_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i  (y_q),
    .b_i  (w_bus),
    .op_i (alu_op_e'(dp.alu_op_i)),
    .lo_o (w_alu_lo),
    .hi_o (w_alu_hi)
  );

  // General-purpose register file; R0 is a real storage location
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (dp.reg_in_i) begin
      gpr_q[dp.reg_sel_i] <= w_bus;
    end
  end

  // Program counter: a bus load overrides the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (dp.pc_in_i) begin
      pc_q <= w_bus;
    end else if (dp.inc_pc_i) begin
      pc_q <= pc_q + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  // Bus-loaded working registers and I/O port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q     <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      inport_q  <= '0;
      outport_q <= '0;
    end else begin
      inport_q <= dp.in_data_i;
      if (dp.mar_in_i)     mar_q     <= w_bus[ADDR_W-1:0];
      if (dp.y_in_i)       y_q       <= w_bus;
      if (dp.hi_in_i)      hi_q      <= w_bus;
      if (dp.lo_in_i)      lo_q      <= w_bus;
      if (dp.outport_in_i) outport_q <= w_bus;
      if (dp.z_in_i) begin
        zlo_q <= w_alu_lo;
        zhi_q <= w_alu_hi;
      end
    end
  end

  // MDR: completing read data takes precedence over a same-cycle bus load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdr_q <= '0;
    end else if (w_rd_load) begin
      mdr_q <= dp.mem_rdata_i;
    end else if (dp.mdr_in_i) begin
      mdr_q <= w_bus;
    end
  end

  // Memory FSM state and latched direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
    end
  end

  // Memory FSM next state and handshake outputs
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    w_rd_load      = 1'b0;
    dp.mem_req_o   = 1'b0;
    dp.mem_we_o    = 1'b0;
    dp.mem_done_o  = 1'b0;
    dp.mem_busy_o  = (state_q != MEM_IDLE);
    unique case (state_q)
      MEM_IDLE: begin
        // A simultaneous read and write request is malformed and dropped
        if (dp.mem_rd_i ^ dp.mem_wr_i) begin
          state_d = MEM_REQ;
          we_d    = dp.mem_wr_i;
        end
      end
      MEM_REQ: begin
        dp.mem_req_o = 1'b1;
        dp.mem_we_o  = we_q;
        if (dp.mem_ack_i) begin
          w_rd_load = ~we_q;
          state_d   = MEM_DONE;
        end
      end
      MEM_DONE: begin
        dp.mem_done_o = 1'b1;
        state_d       = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

`ifdef SRC_DP_BUS_CHECK_EN
  logic bus_err_q;

  // Sticky contention flag: set when two or more sources drive the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else if (count_bus_src(w_src_sel) > 4'd1) begin
      bus_err_q <= 1'b1;
    end
  end

  assign dp.bus_err_o = bus_err_q;
`else
  assign dp.bus_err_o = 1'b0;
`endif

  assign dp.bus_out_o   = w_bus;
  assign dp.out_data_o  = outport_q;
  assign dp.mem_addr_o  = mar_q;
  assign dp.mem_wdata_o = mdr_q;

endmodule

`default_nettype wire

// File: tb/tb_src_bus_datapath.sv
// +----------------------------------------------------------------------+
// | Module    : tb_src_bus_datapath                                      |
// | Purpose   : Self-checking bench for src_bus_datapath (RESET_PC=0x10).|
// |             Honours SRC_DP_BUS_CHECK_EN for the contention check.    |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_src_bus_datapath;
  import src_dp_pkg::*;

  localparam int          c_DATA_W   = 32;
  localparam int          c_NUM_REGS = 16;
  localparam int          c_ADDR_W   = 9;
  localparam logic [31:0] c_RESET_PC = 32'h10;
`ifdef SRC_DP_BUS_CHECK_EN
  localparam logic [31:0] c_EXP_ERR = 32'd1;
`else
  localparam logic [31:0] c_EXP_ERR = 32'd0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } alu_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  src_bus_datapath_if #(.DATA_W(c_DATA_W), .NUM_REGS(c_NUM_REGS), .ADDR_W(c_ADDR_W)) bif ();

  src_bus_datapath #(
    .DATA_W(c_DATA_W), .NUM_REGS(c_NUM_REGS), .ADDR_W(c_ADDR_W), .RESET_PC(c_RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (bif.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q [$];
  alu_vec_t    vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_sb(input string name, input logic [31:0] act);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h expected <scoreboard empty>", name, act);
    end else begin
      chk(name, act, sb_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bif.reg_sel_i = '0;  bif.reg_in_i = 0;   bif.reg_out_i = 0;   bif.ba_out_i = 0;
    bif.pc_in_i = 0;     bif.pc_out_i = 0;   bif.inc_pc_i = 0;    bif.mar_in_i = 0;
    bif.mdr_in_i = 0;    bif.mdr_out_i = 0;  bif.y_in_i = 0;      bif.z_in_i = 0;
    bif.zhi_out_i = 0;   bif.zlo_out_i = 0;  bif.hi_in_i = 0;     bif.hi_out_i = 0;
    bif.lo_in_i = 0;     bif.lo_out_i = 0;   bif.inport_out_i = 0; bif.outport_in_i = 0;
    bif.alu_op_i = '0;   bif.mem_rd_i = 0;   bif.mem_wr_i = 0;    bif.mem_ack_i = 0;
  endtask

  // Put a value on the bus through the input port (one cycle to sample In_Data)
  task automatic inj(input logic [31:0] v);
    bif.in_data_i = v;
    step();
    bif.inport_out_i = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit done;

    vec[0] = '{3'd0, 32'd5,         32'd7,         32'd12,        32'd0};
    vec[1] = '{3'd0, 32'hFFFFFFFF,  32'd2,         32'd1,         32'd1};
    vec[2] = '{3'd1, 32'd10,        32'd3,         32'd7,         32'd0};
    vec[3] = '{3'd1, 32'd3,         32'd5,         32'hFFFFFFFE,  32'd1};
    vec[4] = '{3'd2, 32'h0000F0F0,  32'h0000FF00,  32'h0000F000,  32'd0};
    vec[5] = '{3'd3, 32'h0000F0F0,  32'h00000F0F,  32'h0000FFFF,  32'd0};
    vec[6] = '{3'd4, 32'h80000001,  32'h00000021,  32'h00000002,  32'd0};
    vec[7] = '{3'd5, 32'h80000000,  32'd31,        32'd1,         32'd0};
    vec[8] = '{3'd6, 32'd123,       32'd1,         32'hFFFFFFFF,  32'd0};
    vec[9] = '{3'd7, 32'd0,         32'h0F0F0F0F,  32'hF0F0F0F0,  32'd0};

    clr();
    bif.in_data_i   = '0;
    bif.mem_rdata_i = '0;
    step();
    step();
    chk("rst_bus_idle", bif.bus_out_o, 32'd0);
    chk("rst_mem_req", {31'd0, bif.mem_req_o}, 32'd0);
    chk("rst_mem_busy", {31'd0, bif.mem_busy_o}, 32'd0);
    chk("rst_mem_done", {31'd0, bif.mem_done_o}, 32'd0);
    chk("rst_bus_err", {31'd0, bif.bus_err_o}, 32'd0);
    rst_n = 1'b1;

    // PC reset value and two increments
    bif.pc_out_i = 1;
    #1 chk("pc_reset", bif.bus_out_o, c_RESET_PC);
    bif.inc_pc_i = 1;
    step();
    step();
    bif.inc_pc_i = 0;
    #1 chk("pc_inc2", bif.bus_out_o, c_RESET_PC + 32'd2);
    clr();

    // R3 = all ones, Y = R3, ADD bus=1 -> ZLO=0, ZHI=1
    inj(32'hFFFFFFFF);
    bif.reg_in_i = 1; bif.reg_sel_i = 4'd3;
    step(); clr();
    bif.reg_out_i = 1; bif.reg_sel_i = 4'd3; bif.y_in_i = 1;
    #1 chk("r3_read", bif.bus_out_o, 32'hFFFFFFFF);
    step(); clr();
    inj(32'd1);
    bif.alu_op_i = 3'd0; bif.z_in_i = 1;
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd1);
    step(); clr();
    bif.zlo_out_i = 1;
    #1 chk_sb("add_wrap_zlo", bif.bus_out_o);
    bif.zlo_out_i = 0; bif.zhi_out_i = 1;
    #1 chk_sb("add_wrap_zhi", bif.bus_out_o);
    clr();

    // R0 stored value vs base-address zero
    inj(32'h77);
    bif.reg_in_i = 1; bif.reg_sel_i = 4'd0;
    step(); clr();
    bif.reg_out_i = 1; bif.reg_sel_i = 4'd0;
    #1 chk("r0_reg_out", bif.bus_out_o, 32'h77);
    bif.reg_out_i = 0; bif.ba_out_i = 1;
    #1 chk("r0_ba_out", bif.bus_out_o, 32'd0);
    bif.reg_sel_i = 4'd3;
    #1 chk("r3_ba_out", bif.bus_out_o, 32'hFFFFFFFF);
    clr();

    // HI, LO and output port load from the bus
    inj(32'hA5A50F0F);
    bif.hi_in_i = 1; bif.lo_in_i = 1; bif.outport_in_i = 1;
    step(); clr();
    #1 chk("outport", bif.out_data_o, 32'hA5A50F0F);
    bif.hi_out_i = 1;
    #1 chk("hi_out", bif.bus_out_o, 32'hA5A50F0F);
    bif.hi_out_i = 0; bif.lo_out_i = 1;
    #1 chk("lo_out", bif.bus_out_o, 32'hA5A50F0F);
    clr();

    // ALU vector table
    for (int i = 0; i < 10; i++) begin
      inj(vec[i].a);
      bif.y_in_i = 1;
      step(); clr();
      inj(vec[i].b);
      bif.alu_op_i = vec[i].op; bif.z_in_i = 1;
      sb_q.push_back(vec[i].lo);
      sb_q.push_back(vec[i].hi);
      step(); clr();
      bif.zlo_out_i = 1;
      #1 chk_sb($sformatf("alu%0d_zlo", i), bif.bus_out_o);
      bif.zlo_out_i = 0; bif.zhi_out_i = 1;
      #1 chk_sb($sformatf("alu%0d_zhi", i), bif.bus_out_o);
      clr();
    end

    // Memory read with 4 wait cycles; MDR_In collides with completion
    inj(32'd5);
    bif.mar_in_i = 1;
    step(); clr();
    #1 chk("mar_addr", {23'd0, bif.mem_addr_o}, 32'd5);
    bif.in_data_i = 32'hBEEF;
    bif.mem_rd_i = 1;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 20) begin
      step();
      cyc++;
      bif.mem_rd_i = 0; bif.inport_out_i = 0; bif.mdr_in_i = 0;
      if (cyc == 5) begin
        bif.mem_ack_i = 1; bif.mem_rdata_i = 32'hCAFE;
        bif.inport_out_i = 1; bif.mdr_in_i = 1;
        sb_q.push_back(32'hCAFE);
      end else begin
        bif.mem_ack_i = 0; bif.mem_rdata_i = '0;
      end
      #1;
      if (cyc == 1) begin
        chk("rd_req", {31'd0, bif.mem_req_o}, 32'd1);
        chk("rd_we", {31'd0, bif.mem_we_o}, 32'd0);
      end
      if (bif.mem_done_o) done = 1;
    end
    chk("rd_done_cycle", cyc, 32'd6);
    bif.mdr_out_i = 1;
    #1 chk_sb("rd_mdr_bus", bif.bus_out_o);
    clr();
    step();
    chk("rd_idle", {31'd0, bif.mem_busy_o}, 32'd0);

    // Read and write together are ignored
    bif.mem_rd_i = 1; bif.mem_wr_i = 1;
    step(); clr();
    chk("rdwr_ignored", {31'd0, bif.mem_busy_o}, 32'd0);

    // Write, with a second request while busy
    inj(32'h1234);
    bif.mdr_in_i = 1;
    step(); clr();
    bif.mem_wr_i = 1;
    step();
    bif.mem_wr_i = 0;
    #1 chk("wr_req", {31'd0, bif.mem_req_o}, 32'd1);
    chk("wr_we", {31'd0, bif.mem_we_o}, 32'd1);
    chk("wr_wdata", bif.mem_wdata_o, 32'h1234);
    bif.mem_wr_i = 1;
    step();
    bif.mem_wr_i = 0; bif.mem_ack_i = 1;
    #1 chk("wr_req_held", {31'd0, bif.mem_req_o}, 32'd1);
    step();
    bif.mem_ack_i = 0;
    #1 chk("wr_done", {31'd0, bif.mem_done_o}, 32'd1);
    step();
    chk("wr_req_drop", {31'd0, bif.mem_req_o}, 32'd0);
    step();
    chk("wr_no_extra", {31'd0, bif.mem_busy_o}, 32'd0);
    bif.mdr_out_i = 1;
    #1 chk("wr_mdr_kept", bif.bus_out_o, 32'h1234);
    clr();

    // Asynchronous reset in the middle of a transfer
    bif.mem_rd_i = 1;
    step();
    bif.mem_rd_i = 0;
    #1 chk("mid_req", {31'd0, bif.mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_rst_req", {31'd0, bif.mem_req_o}, 32'd0);
    chk("mid_rst_idle", {31'd0, bif.mem_busy_o}, 32'd0);
    bif.mdr_out_i = 1;
    #1 chk("mid_rst_mdr", bif.bus_out_o, 32'd0);
    clr();
    step();
    rst_n = 1'b1;

    // Bus contention: priority keeps PC; flag depends on build
    bif.pc_out_i = 1; bif.mdr_out_i = 1; bif.reg_out_i = 1; bif.reg_sel_i = 4'd3;
    #1 chk("prio_pc", bif.bus_out_o, c_RESET_PC);
    step(); clr();
    #1 chk("bus_err_set", {31'd0, bif.bus_err_o}, c_EXP_ERR);
    step();
    chk("bus_err_sticky", {31'd0, bif.bus_err_o}, c_EXP_ERR);
    rst_n = 1'b0;
    #1 chk("bus_err_rst", {31'd0, bif.bus_err_o}, 32'd0);
    step();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
